frame_serialiser: RTL and testbench

Reader end of the packet frame buffer.
- Watches the buffer's frame count and pulses a next-frame request.
- Captures the 128-bit frame after the buffer's RAM read latency, then emits it as 16 bytes on a valid/ready byte stream toward the output handler (USB/serial).
- Sits between the frame buffer and the byte transport.
- Handles one frame at a time; no prefetch.

---
 rtl/frame_serialiser_pkg.sv | 23 ++
 rtl/frame_serialiser.sv | 115 +++++++++++
 tb/tb_frame_serialiser.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_serialiser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_serialiser_pkg
// Description : Shared types and constants for the frame buffer reader.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_serialiser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam int FRAME_W     = 128;
    localparam int FRAME_BYTES = 16;
    localparam int BYTE_IDX_W  = 4;

    // Must track the read pipeline depth of the frame buffer RAM.
    localparam int RD_LATENCY_DEFAULT = 2;

endpackage : frame_serialiser_pkg
`default_nettype wire

// File: rtl/frame_serialiser.sv
`default_nettype none
// ============================================================================
// Module      : frame_serialiser
// Description : Pulls 128-bit frames from the frame buffer and streams them
//               out little-endian as 16 bytes on a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_serialiser
    import frame_serialiser_pkg::*;
#(
    parameter int BUFFLENLOG2 = 9,
    parameter int RD_LATENCY  = RD_LATENCY_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FRAME_W-1:0]     Frame,
    input  logic [BUFFLENLOG2-1:0] FramesCnt,
    output logic                   FrameNext,
    output logic [7:0]             TxByte,
    output logic                   TxValid,
    input  logic                   TxReady,
    output logic                   TxFirst,
    output logic                   TxLast,
    output logic                   Busy,
    output logic [15:0]            FramesSent
);

    localparam int                    c_WAIT_W   = $clog2(RD_LATENCY + 1);
    localparam logic [c_WAIT_W-1:0]   c_WAIT_LD  = c_WAIT_W'(RD_LATENCY);
    localparam logic [BYTE_IDX_W-1:0] c_LAST_IDX = BYTE_IDX_W'(FRAME_BYTES - 1);

    state_t                r_state;
    state_t                w_nextState;
    logic                  r_frameNext;
    logic [c_WAIT_W-1:0]   r_waitCnt;
    logic [FRAME_W-1:0]    r_shift;
    logic [BYTE_IDX_W-1:0] r_idx;
    logic [15:0]           r_framesSent;
    logic                  w_frameAvail;
    logic                  w_lastAccept;

    assign w_frameAvail = (FramesCnt != '0);
    assign w_lastAccept = (r_state == ST_SEND) && TxReady && (r_idx == c_LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_frameAvail)       w_nextState = ST_WAIT;
            ST_WAIT: if (r_waitCnt == '0)    w_nextState = ST_SEND;
            ST_SEND: if (w_lastAccept)       w_nextState = ST_IDLE;
            default:                         w_nextState = ST_IDLE;
        endcase
    end

    // The request is registered so it stays low through reset; the wait
    // count starts together with it, so Frame is captured RD_LATENCY edges
    // after the buffer samples the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frameNext  <= 1'b0;
            r_waitCnt    <= '0;
            r_shift      <= '0;
            r_idx        <= '0;
            r_framesSent <= '0;
        end else begin
            r_frameNext <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_frameAvail) begin
                        r_frameNext <= 1'b1;
                        r_waitCnt   <= c_WAIT_LD;
                    end
                end
                ST_WAIT: begin
                    if (r_waitCnt == '0) begin
                        r_shift <= Frame;
                        r_idx   <= '0;
                    end else begin
                        r_waitCnt <= r_waitCnt - c_WAIT_W'(1);
                    end
                end
                ST_SEND: begin
                    if (TxReady) begin
                        r_shift <= {8'h00, r_shift[FRAME_W-1:8]};
                        r_idx   <= r_idx + BYTE_IDX_W'(1);
                        if (r_idx == c_LAST_IDX) begin
                            r_framesSent <= r_framesSent + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        FrameNext  = r_frameNext;
        TxValid    = (r_state == ST_SEND);
        TxByte     = (r_state == ST_SEND) ? r_shift[7:0] : 8'h00;
        TxFirst    = (r_state == ST_SEND) && (r_idx == '0);
        TxLast     = (r_state == ST_SEND) && (r_idx == c_LAST_IDX);
        Busy       = (r_state != ST_IDLE);
        FramesSent = r_framesSent;
    end

endmodule : frame_serialiser
`default_nettype wire

// File: tb/tb_frame_serialiser.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_serialiser
// Description : Directed self-checking bench for frame_serialiser.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_frame_serialiser;

    localparam int BUFFLENLOG2 = 9;
    localparam int RD_LATENCY  = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [127:0]           Frame = '0;
    logic [BUFFLENLOG2-1:0] FramesCnt;
    logic                   FrameNext;
    logic [7:0]             TxByte;
    logic                   TxValid;
    logic                   TxReady;
    logic                   TxFirst;
    logic                   TxLast;
    logic                   Busy;
    logic [15:0]            FramesSent;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    frame_serialiser #(
        .BUFFLENLOG2(BUFFLENLOG2),
        .RD_LATENCY (RD_LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Frame     (Frame),
        .FramesCnt (FramesCnt),
        .FrameNext (FrameNext),
        .TxByte    (TxByte),
        .TxValid   (TxValid),
        .TxReady   (TxReady),
        .TxFirst   (TxFirst),
        .TxLast    (TxLast),
        .Busy      (Busy),
        .FramesSent(FramesSent)
    );

    // Buffer model with a two-cycle read: request sampled at E0, RAM data and
    // the decremented count appear after E0+1, ready for capture at E0+2.
    logic [127:0] mem [0:15];
    int           loaded = 0;
    int           served = 0;
    logic         fnD    = 1'b0;

    always @(posedge clk) begin
        fnD <= FrameNext;
        if (fnD) begin
            Frame  <= mem[served % 16];
            served <= served + 1;
        end
    end

    assign FramesCnt = BUFFLENLOG2'(loaded - served);

    function automatic logic [127:0] mkFrame(input logic [7:0] base);
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[8*i +: 8] = base + 8'(i);
        return f;
    endfunction

    task automatic test_reset;
        rst     = 1'b1;
        TxReady = 1'b0;
        loaded  = served;
        repeat (3) @(negedge clk);
        checks++;
        if ({FrameNext, TxValid, TxFirst, TxLast, Busy} !== 5'b0 || TxByte !== 8'h00 || FramesSent !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: fn/v/f/l/busy=%b byte=%h sent=%h, want 00000 00 0000",
                     {FrameNext, TxValid, TxFirst, TxLast, Busy}, TxByte, FramesSent);
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (FrameNext !== 1'b0 || TxValid !== 1'b0 || Busy !== 1'b0) begin
                failures++;
                $display("FAIL idle_quiet cyc%0d: fn=%b valid=%b busy=%b, want 0 0 0", c, FrameNext, TxValid, Busy);
            end
        end
        checks++;
        if (FramesSent !== 16'h0) begin
            failures++;
            $display("FAIL idle_sent: got %h want 0000", FramesSent);
        end
    endtask

    task automatic test_single_frame;
        int fnCount = 0, nByte = 0, fnCyc = -1, validCyc = -1;
        mem[served % 16] = mkFrame(8'h00);
        TxReady = 1'b1;
        loaded  = served + 1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (FrameNext) begin
                fnCount++;
                if (fnCyc < 0) fnCyc = c;
            end
            if (validCyc >= 0 && nByte < 16) begin
                checks++;
                if (TxValid !== 1'b1) begin
                    failures++;
                    $display("FAIL single_gap byte%0d: valid=%b want 1", nByte, TxValid);
                end
            end
            if (TxValid) begin
                if (validCyc < 0) validCyc = c;
                checks++;
                if (nByte >= 16) begin
                    failures++;
                    $display("FAIL single_extra: byte=%h after 16 bytes, want none", TxByte);
                end else if (TxByte !== 8'(nByte) || TxFirst !== (nByte == 0) || TxLast !== (nByte == 15)) begin
                    failures++;
                    $display("FAIL single_byte%0d: byte=%h first=%b last=%b, want %h %b %b",
                             nByte, TxByte, TxFirst, TxLast, 8'(nByte), nByte == 0, nByte == 15);
                end
                nByte++;
            end
        end
        checks++;
        if (fnCount != 1) begin
            failures++;
            $display("FAIL single_pulses: got %0d want 1", fnCount);
        end
        checks++;
        if (validCyc - fnCyc != RD_LATENCY + 1) begin
            failures++;
            $display("FAIL single_latency: got %0d cycles want %0d", validCyc - fnCyc, RD_LATENCY + 1);
        end
        checks++;
        if (nByte != 16 || FramesSent !== 16'd1 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL single_done: bytes=%0d sent=%0d busy=%b, want 16 1 0", nByte, FramesSent, Busy);
        end
    endtask

    task automatic test_backpressure;
        int   nByte = 0, k = 0;
        logic stalled = 1'b0, rdy;
        logic [7:0] prevByte = '0;
        logic prevFirst = 1'b0, prevLast = 1'b0;
        logic [3:0] pat = 4'b1001;   // ready sequence 1,0,0,1 read from bit 3 down
        mem[served % 16] = mkFrame(8'h40);
        TxReady = 1'b1;
        loaded  = served + 1;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            rdy = 1'b1;
            if (nByte > 0 && nByte < 16) begin
                checks++;
                if (TxValid !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_gap byte%0d: valid=%b want 1", nByte, TxValid);
                end
            end
            if (TxValid && nByte < 16) begin
                checks++;
                if (stalled) begin
                    if (TxByte !== prevByte || TxFirst !== prevFirst || TxLast !== prevLast) begin
                        failures++;
                        $display("FAIL bp_hold byte%0d: byte=%h first=%b last=%b, want %h %b %b",
                                 nByte, TxByte, TxFirst, TxLast, prevByte, prevFirst, prevLast);
                    end
                end else if (TxByte !== 8'h40 + 8'(nByte) || TxFirst !== (nByte == 0) || TxLast !== (nByte == 15)) begin
                    failures++;
                    $display("FAIL bp_byte%0d: byte=%h first=%b last=%b, want %h %b %b",
                             nByte, TxByte, TxFirst, TxLast, 8'h40 + 8'(nByte), nByte == 0, nByte == 15);
                end
                rdy       = pat[3 - (k % 4)];
                k++;
                prevByte  = TxByte;
                prevFirst = TxFirst;
                prevLast  = TxLast;
                stalled   = !rdy;
                if (rdy) nByte++;
            end
            TxReady = rdy;
        end
        TxReady = 1'b1;
        checks++;
        if (nByte != 16 || FramesSent !== 16'd2 || TxValid !== 1'b0) begin
            failures++;
            $display("FAIL bp_done: bytes=%0d sent=%0d valid=%b, want 16 2 0", nByte, FramesSent, TxValid);
        end
    endtask

    task automatic test_back_to_back;
        int fnCount = 0, nByte = 0;
        int pc [0:3];
        logic [7:0] bases [0:2];
        logic [7:0] exp;
        bases[0] = 8'h80; bases[1] = 8'h90; bases[2] = 8'hA0;
        for (int f = 0; f < 3; f++) mem[(served + f) % 16] = mkFrame(bases[f]);
        TxReady = 1'b1;
        loaded  = served + 3;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (FrameNext) begin
                if (fnCount < 4) pc[fnCount] = c;
                fnCount++;
            end
            if (TxValid) begin
                checks++;
                if (nByte >= 48) begin
                    failures++;
                    $display("FAIL b2b_extra: byte=%h after 48 bytes", TxByte);
                end else begin
                    exp = bases[nByte / 16] + 8'(nByte % 16);
                    if (TxByte !== exp || TxFirst !== (nByte % 16 == 0) || TxLast !== (nByte % 16 == 15)) begin
                        failures++;
                        $display("FAIL b2b_byte%0d: byte=%h first=%b last=%b, want %h %b %b",
                                 nByte, TxByte, TxFirst, TxLast, exp, nByte % 16 == 0, nByte % 16 == 15);
                    end
                end
                nByte++;
            end
        end
        checks++;
        if (fnCount != 3) begin
            failures++;
            $display("FAIL b2b_pulses: got %0d want 3", fnCount);
        end else begin
            for (int p = 1; p < 3; p++) begin
                checks++;
                if (pc[p] - pc[p-1] < RD_LATENCY + 17) begin
                    failures++;
                    $display("FAIL b2b_spacing%0d: got %0d want >=%0d", p, pc[p] - pc[p-1], RD_LATENCY + 17);
                end
            end
        end
        checks++;
        if (nByte != 48 || FramesSent !== 16'd5) begin
            failures++;
            $display("FAIL b2b_done: bytes=%0d sent=%0d, want 48 5", nByte, FramesSent);
        end
    endtask

    task automatic test_reset_mid_frame;
        int nByte = 0, fnCount = 0;
        logic reached = 1'b0;
        mem[served % 16]       = mkFrame(8'hC0);
        mem[(served + 1) % 16] = mkFrame(8'hD0);
        TxReady = 1'b1;
        loaded  = served + 2;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (TxValid) begin
                checks++;
                if (TxByte !== 8'hC0 + 8'(nByte)) begin
                    failures++;
                    $display("FAIL mr_pre_byte%0d: byte=%h want %h", nByte, TxByte, 8'hC0 + 8'(nByte));
                end
                if (nByte == 7) begin
                    reached = 1'b1;
                    break;
                end
                nByte++;
            end
        end
        checks++;
        if (!reached) begin
            failures++;
            $display("FAIL mr_timeout: byte 7 never offered, got %0d bytes", nByte);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (TxValid !== 1'b0 || Busy !== 1'b0 || FramesSent !== 16'd0 || TxByte !== 8'h00) begin
            failures++;
            $display("FAIL mr_async: valid=%b busy=%b sent=%0d byte=%h, want 0 0 0 00", TxValid, Busy, FramesSent, TxByte);
        end
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        nByte = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (FrameNext) fnCount++;
            if (TxValid) begin
                checks++;
                if (nByte >= 16 || TxByte !== 8'hD0 + 8'(nByte) || TxFirst !== (nByte == 0) || TxLast !== (nByte == 15)) begin
                    failures++;
                    $display("FAIL mr_post_byte%0d: byte=%h first=%b last=%b, want %h %b %b",
                             nByte, TxByte, TxFirst, TxLast, 8'hD0 + 8'(nByte), nByte == 0, nByte == 15);
                end
                nByte++;
            end
        end
        checks++;
        if (fnCount != 1 || nByte != 16 || FramesSent !== 16'd1) begin
            failures++;
            $display("FAIL mr_done: pulses=%0d bytes=%0d sent=%0d, want 1 16 1", fnCount, nByte, FramesSent);
        end
    endtask

    task automatic test_wrap;
        int nByte = 0;
        @(negedge clk);
        force dut.r_framesSent = 16'hFFFF;
        @(negedge clk);
        release dut.r_framesSent;
        #1;
        checks++;
        if (FramesSent !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_preload: got %h want ffff", FramesSent);
        end
        mem[served % 16] = mkFrame(8'hE0);
        TxReady = 1'b1;
        loaded  = served + 1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (TxValid) begin
                checks++;
                if (nByte >= 16 || TxByte !== 8'hE0 + 8'(nByte)) begin
                    failures++;
                    $display("FAIL wrap_byte%0d: byte=%h want %h", nByte, TxByte, 8'hE0 + 8'(nByte));
                end
                nByte++;
            end
        end
        checks++;
        if (nByte != 16 || FramesSent !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_done: bytes=%0d sent=%h, want 16 0000", nByte, FramesSent);
        end
    endtask

    initial begin
        rst     = 1'b1;
        TxReady = 1'b0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_frame_serialiser
`default_nettype wire
